// File: rtl/vector_cache_pkg.sv
// Shared types and sizing for the vector cache read path.
// Holds the upstream data payload, the master count and the read-response buffer depth.
package vector_cache_pkg;

    localparam int N                 = 8;
    localparam int MID_W             = $clog2(N);
    localparam int RD_RESP_BUF_DEPTH = 4;

    typedef struct packed {
        logic [MID_W-1:0] master_id;
        logic [4:0]       tag;
    } txnid_t;

    typedef struct packed {
        txnid_t      txnid;
        logic [31:0] data;
    } us_data_pld_t;

endpackage

// File: rtl/vc_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered read port.
// The caller qualifies push/pop: pop only when not empty, push only when not full or
// when popping in the same cycle. The output register always holds the entry at the
// head pointer, forwarding the write data when a push lands directly on the new head.
module vc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr_nxt;
    logic [AW:0]      rd_ptr_nxt;
    logic [WIDTH-1:0] mem [DEPTH];

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;

    // Next pointer values; the extra MSB wraps naturally on overflow of the add.
    always_comb begin
        wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
        rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
    end

    // Pointer registers; reset discards any buffered contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
        end
    end

    // Storage array write port; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Registered head read; forward write data when the pushed slot becomes the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (push && (wr_ptr[AW-1:0] == rd_ptr_nxt[AW-1:0])) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[rd_ptr_nxt[AW-1:0]];
        end
    end

endmodule

// File: rtl/us_rd_resp_egress_buf.sv
// Per-master read-response egress buffer sitting behind the read-data decode crossbar.
// The decode lane cannot be stalled, so every beat lands in a FIFO that is drained towards
// the master with valid/ready; each dequeue returns one credit to the read issuer.
module us_rd_resp_egress_buf
    import vector_cache_pkg::*;
#(
    parameter int DEPTH         = RD_RESP_BUF_DEPTH,
    parameter int MASTER_ID     = 0,
    parameter bit OVF_ASSERT_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_vld,
    input  us_data_pld_t             in_pld,
    output logic                     us_rvalid,
    output us_data_pld_t             us_rpld,
    input  logic                     us_rready,
    output logic                     credit_rtn,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     err_overflow,
    output logic                     err_misroute
);

    localparam int               PW    = $bits(us_data_pld_t);
    localparam logic [MID_W-1:0] MY_ID = MID_W'(MASTER_ID);

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [PW-1:0] fifo_rdata;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign us_rvalid = !empty;
    assign pop       = us_rvalid && us_rready;
    assign push      = in_vld && (!full || pop);
    assign us_rpld   = us_data_pld_t'(fifo_rdata);

    vc_sync_fifo #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (in_pld),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty),
        .count (occupancy)
    );

    // Credit pulse one cycle after each dequeue, plus sticky error flags cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_rtn   <= 1'b0;
            err_overflow <= 1'b0;
            err_misroute <= 1'b0;
        end else begin
            credit_rtn <= pop;
            if (in_vld && full && !pop) begin
                err_overflow <= 1'b1;
            end
            if (in_vld && (in_pld.txnid.master_id != MY_ID)) begin
                err_misroute <= 1'b1;
            end
        end
    end

    // A beat arriving with no room means the issuer's credit accounting is broken.
    // Benches that provoke overflow on purpose turn this off through OVF_ASSERT_EN.
    ovf_check_a: assert property (@(posedge clk) disable iff (rst || !OVF_ASSERT_EN)
        !(in_vld && full && !pop))
        else $error("us_rd_resp_egress_buf: beat arrived while full");

endmodule

// File: tb/tb_us_rd_resp_egress_buf.sv
// Bench for us_rd_resp_egress_buf: directed scenarios then random traffic.
// The driver keeps a queue-level model of the buffer and pushes every accepted beat onto
// a scoreboard; a negedge monitor checks the handshake outputs against that model.
module tb_us_rd_resp_egress_buf;
    import vector_cache_pkg::*;

    localparam int DEPTH     = 4;
    localparam int MASTER_ID = 3;
    localparam int OW        = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_vld = 1'b0;
    us_data_pld_t  in_pld = '0;
    logic          us_rvalid;
    us_data_pld_t  us_rpld;
    logic          us_rready = 1'b0;
    logic          credit_rtn;
    logic [OW-1:0] occupancy;
    logic          err_overflow;
    logic          err_misroute;

    int checks   = 0;
    int failures = 0;

    us_data_pld_t exp_q[$];
    int           model_occ = 0;
    bit           model_ovf = 1'b0;
    bit           model_mis = 1'b0;
    bit           last_pop  = 1'b0;

    int cyc_occ    = 0;
    bit cyc_ovf    = 1'b0;
    bit cyc_mis    = 1'b0;
    bit cyc_credit = 1'b0;
    bit cyc_valid  = 1'b0;

    us_data_pld_t nop = '0;

    always #5 clk = ~clk;

    us_rd_resp_egress_buf #(
        .DEPTH         (DEPTH),
        .MASTER_ID     (MASTER_ID),
        .OVF_ASSERT_EN (1'b0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_vld       (in_vld),
        .in_pld       (in_pld),
        .us_rvalid    (us_rvalid),
        .us_rpld      (us_rpld),
        .us_rready    (us_rready),
        .credit_rtn   (credit_rtn),
        .occupancy    (occupancy),
        .err_overflow (err_overflow),
        .err_misroute (err_misroute)
    );

    function automatic us_data_pld_t mk_pld(input int mid, input int data);
        us_data_pld_t p;
        p.txnid.master_id = MID_W'(mid);
        p.txnid.tag       = 5'($urandom_range(0, 31));
        p.data            = 32'(data);
        return p;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Drives one cycle of inputs and advances the reference model by one clock edge.
    task automatic applyStimulus(input bit vld, input us_data_pld_t pld, input bit rdy);
        bit pop_e;
        bit acc;
        @(posedge clk);
        #1;
        in_vld    = vld;
        in_pld    = pld;
        us_rready = rdy;
        pop_e = (model_occ > 0) && rdy;
        acc   = vld && ((model_occ - int'(pop_e)) < DEPTH);
        cyc_occ    = model_occ;
        cyc_ovf    = model_ovf;
        cyc_mis    = model_mis;
        cyc_credit = last_pop;
        cyc_valid  = 1'b1;
        if (acc) exp_q.push_back(pld);
        if (vld && !acc) model_ovf = 1'b1;
        if (vld && (pld.txnid.master_id != MID_W'(MASTER_ID))) model_mis = 1'b1;
        model_occ = model_occ - int'(pop_e) + int'(acc);
        last_pop  = pop_e;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_rvalid"}, 64'(us_rvalid), 64'(0));
        checkOutput({tag, "_credit"}, 64'(credit_rtn), 64'(0));
        checkOutput({tag, "_occ"}, 64'(occupancy), 64'(0));
        checkOutput({tag, "_ovf"}, 64'(err_overflow), 64'(0));
        checkOutput({tag, "_mis"}, 64'(err_misroute), 64'(0));
    endtask

    // Monitor: compares status outputs with the model and pops the scoreboard on handshakes.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && cyc_valid) begin
                checkOutput("rvalid", 64'(us_rvalid), 64'(cyc_occ != 0));
                checkOutput("occupancy", 64'(occupancy), 64'(cyc_occ));
                checkOutput("credit_rtn", 64'(credit_rtn), 64'(cyc_credit));
                checkOutput("err_overflow", 64'(err_overflow), 64'(cyc_ovf));
                checkOutput("err_misroute", 64'(err_misroute), 64'(cyc_mis));
                if (us_rvalid) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("rpld_unexpected", 64'(1), 64'(0));
                    end else begin
                        checkOutput("rpld", 64'(us_rpld), 64'(exp_q[0]));
                        if (us_rready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");
        checkOutput("reset_rpld", 64'(us_rpld), 64'(0));
        rst = 1'b0;

        // Single beat, accepted on the first cycle it is visible
        applyStimulus(1'b1, mk_pld(MASTER_ID, 32'hA5), 1'b0);
        applyStimulus(1'b0, nop, 1'b1);
        applyStimulus(1'b0, nop, 1'b0);
        applyStimulus(1'b0, nop, 1'b0);

        // Fill to DEPTH with no ready
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, mk_pld(MASTER_ID, i), 1'b0);
        applyStimulus(1'b0, nop, 1'b0);

        // Overflow: extra beat while full is dropped
        applyStimulus(1'b1, mk_pld(MASTER_ID, 32'h55), 1'b0);
        applyStimulus(1'b0, nop, 1'b0);

        // Full with simultaneous push and pop, then drain
        applyStimulus(1'b1, mk_pld(MASTER_ID, 4), 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, nop, 1'b1);

        // Misrouted beat is flagged but still delivered
        applyStimulus(1'b1, mk_pld(5, 32'h77), 1'b0);
        applyStimulus(1'b0, nop, 1'b1);
        applyStimulus(1'b0, nop, 1'b0);

        // Reset mid-stream with occupancy 2 and a credit pulse in flight
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, mk_pld(MASTER_ID, 32'h100 + i), 1'b0);
        applyStimulus(1'b0, nop, 1'b1);
        applyStimulus(1'b0, nop, 1'b0);
        @(negedge clk);
        #1;
        rst       = 1'b1;
        cyc_valid = 1'b0;
        #1;
        checkResetState("midrst");
        exp_q.delete();
        model_occ = 0;
        model_ovf = 1'b0;
        model_mis = 1'b0;
        last_pop  = 1'b0;
        in_vld    = 1'b0;
        us_rready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, mk_pld(MASTER_ID, 32'hBEEF), 1'b0);
        applyStimulus(1'b0, nop, 1'b1);
        applyStimulus(1'b0, nop, 1'b0);

        // Random traffic, occasionally misrouted and occasionally overflowing
        for (int i = 0; i < 400; i++) begin
            bit vld;
            bit rdy;
            int mid;
            vld = ($urandom_range(0, 9) < 6);
            rdy = ($urandom_range(0, 9) < 5);
            mid = ($urandom_range(0, 15) == 0) ? 5 : MASTER_ID;
            applyStimulus(vld, mk_pld(mid, int'($urandom)), rdy);
        end

        // Drain everything that was accepted
        for (int i = 0; i < DEPTH + 4; i++) applyStimulus(1'b0, nop, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
